// File: rtl/arashi_rr_cache.sv
// rtl/arashi_rr_cache.sv - multi-thread write-combining cache with round-robin drain into a circular memory
module arashi_rr_cache #(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int FIFO_DEPTH_WIDTH = 2,
  parameter int MEM_WIDTH        = 10
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [2*(1<<THREAD_NUM_WIDTH)-1:0]            ctrl,
  input  logic [DATA_WIDTH*(1<<THREAD_NUM_WIDTH)-1:0]   data_in,
  output logic [(1<<THREAD_NUM_WIDTH)-1:0]              w_ready,
  output logic [(1<<THREAD_NUM_WIDTH)-1:0]              drop_err,
  output logic [DATA_WIDTH*(1<<THREAD_NUM_WIDTH)-1:0]   data_out,
  output logic [(1<<THREAD_NUM_WIDTH)-1:0]              r_valid,
  output logic [MEM_WIDTH:0]                            commit_cnt,
  output logic                                          mem_wrapped
);

  localparam int THREAD_NUM = 1 << THREAD_NUM_WIDTH;
  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_WIDTH;
  localparam int MEM_DEPTH  = 1 << MEM_WIDTH;

  // Occupancy is one bit wider than the FIFO index so "full" is representable.
  localparam logic [FIFO_DEPTH_WIDTH:0] OCC_FULL = (FIFO_DEPTH_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [MEM_WIDTH:0]        CNT_MAX  = (MEM_WIDTH+1)'(MEM_DEPTH);
  localparam logic [MEM_WIDTH-1:0]      PTR_LAST = '1;

  if (THREAD_NUM_WIDTH < 1 || THREAD_NUM_WIDTH > 4) begin : g_bad_thread_width
    $error("arashi_rr_cache: THREAD_NUM_WIDTH must be in 1..4");
  end
  if (FIFO_DEPTH_WIDTH < 1) begin : g_bad_fifo_width
    $error("arashi_rr_cache: FIFO_DEPTH_WIDTH must be >= 1");
  end

  // Per-thread FIFO storage and pointers
  logic [DATA_WIDTH-1:0]       fifo_mem [THREAD_NUM][FIFO_DEPTH];
  logic [FIFO_DEPTH_WIDTH-1:0] head     [THREAD_NUM];
  logic [FIFO_DEPTH_WIDTH-1:0] tail     [THREAD_NUM];
  logic [FIFO_DEPTH_WIDTH:0]   occ      [THREAD_NUM];

  // Circular commit memory; contents deliberately survive reset
  logic [DATA_WIDTH-1:0]       mem [MEM_DEPTH];
  logic [MEM_WIDTH-1:0]        wr_ptr;
  logic [MEM_WIDTH-1:0]        last_addr [THREAD_NUM];
  logic [THREAD_NUM-1:0]       has_data;

  logic [THREAD_NUM_WIDTH-1:0] rr_ptr;
  logic [THREAD_NUM_WIDTH-1:0] cand;
  logic [THREAD_NUM_WIDTH-1:0] grant_idx;
  logic                        grant_valid;
  logic [THREAD_NUM-1:0]       wr_req;
  logic [THREAD_NUM-1:0]       rd_req;
  logic [THREAD_NUM-1:0]       push;
  logic [THREAD_NUM-1:0]       pop;
  logic [DATA_WIDTH-1:0]       commit_word;

  // Request decode and write handshake; w_ready looks only at registered occupancy (no pop bypass)
  always_comb begin
    wr_req  = '0;
    rd_req  = '0;
    w_ready = '0;
    push    = '0;
    for (int i = 0; i < THREAD_NUM; i++) begin
      wr_req[i]  = ctrl[2*i+1];
      rd_req[i]  = ctrl[2*i];
      w_ready[i] = !rst && (occ[i] < OCC_FULL);
      push[i]    = wr_req[i] && w_ready[i];
    end
  end

  // Round-robin grant: first non-empty FIFO scanning upward from rr_ptr
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    cand        = rr_ptr;
    for (int k = 0; k < THREAD_NUM; k++) begin
      cand = rr_ptr + THREAD_NUM_WIDTH'(k);
      if (!grant_valid && occ[cand] != '0) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    pop = '0;
    if (grant_valid) begin
      pop[grant_idx] = 1'b1;
    end
    commit_word = fifo_mem[grant_idx][head[grant_idx]];
  end

  // Data arrays: FIFO pushes and memory commits, blocked entirely during reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < THREAD_NUM; i++) begin
      if (push[i]) begin
        fifo_mem[i][tail[i]] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (!rst && grant_valid) begin
      mem[wr_ptr] <= commit_word;
    end
  end

  // Control state: FIFO pointers, arbitration, read-back and status
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < THREAD_NUM; i++) begin
        head[i]      <= '0;
        tail[i]      <= '0;
        occ[i]       <= '0;
        last_addr[i] <= '0;
      end
      has_data    <= '0;
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      data_out    <= '0;
      r_valid     <= '0;
      drop_err    <= '0;
      commit_cnt  <= '0;
      mem_wrapped <= 1'b0;
    end else begin
      for (int i = 0; i < THREAD_NUM; i++) begin
        if (push[i]) begin
          tail[i] <= tail[i] + 1'b1;
        end
        if (pop[i]) begin
          head[i] <= head[i] + 1'b1;
        end
        case ({push[i], pop[i]})
          2'b10:   occ[i] <= occ[i] + 1'b1;
          2'b01:   occ[i] <= occ[i] - 1'b1;
          default: occ[i] <= occ[i];
        endcase
        if (wr_req[i] && !w_ready[i]) begin
          drop_err[i] <= 1'b1;
        end
        // Read sees start-of-cycle last_addr/has_data, so a same-cycle commit is not visible yet
        r_valid[i] <= rd_req[i];
        if (rd_req[i]) begin
          data_out[i*DATA_WIDTH +: DATA_WIDTH] <= has_data[i] ? mem[last_addr[i]] : '0;
        end
      end
      if (grant_valid) begin
        last_addr[grant_idx] <= wr_ptr;
        has_data[grant_idx]  <= 1'b1;
        wr_ptr               <= wr_ptr + 1'b1;
        rr_ptr               <= grant_idx + 1'b1;
        if (commit_cnt != CNT_MAX) begin
          commit_cnt <= commit_cnt + 1'b1;
        end
        if (wr_ptr == PTR_LAST) begin
          mem_wrapped <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arashi_rr_cache.sv
// tb/tb_arashi_rr_cache.sv - scoreboard testbench for arashi_rr_cache
module tb_arashi_rr_cache;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   ctrl = '0;
  logic [127:0] data_in = '0;
  logic [3:0]   w_ready;
  logic [3:0]   drop_err;
  logic [127:0] data_out;
  logic [3:0]   r_valid;
  logic [3:0]   commit_cnt;
  logic         mem_wrapped;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [4][$];
  logic [31:0] e_word;

  arashi_rr_cache #(
    .DATA_WIDTH(32),
    .THREAD_NUM_WIDTH(2),
    .FIFO_DEPTH_WIDTH(2),
    .MEM_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctrl(ctrl),
    .data_in(data_in),
    .w_ready(w_ready),
    .drop_err(drop_err),
    .data_out(data_out),
    .r_valid(r_valid),
    .commit_cnt(commit_cnt),
    .mem_wrapped(mem_wrapped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_rd(input int t, input logic [31:0] v);
    exp_q[t].push_back(v);
  endtask

  // One clock edge with the given inputs; returns at the following negedge
  task automatic step(input logic [7:0] c, input logic [127:0] d);
    ctrl    = c;
    data_in = d;
    @(negedge clk);
    ctrl    = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(8'h00, '0);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    ctrl = '0;
    #1;
    check("w_ready_in_rst", w_ready, 4'h0);
    @(negedge clk);
    check("rst_w_ready", w_ready, 4'h0);
    check("rst_commit_cnt", commit_cnt, 4'd0);
    check("rst_wrapped", mem_wrapped, 1'b0);
    check("rst_drop_err", drop_err, 4'h0);
    check("rst_r_valid", r_valid, 4'h0);
    check("rst_data_out", data_out, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_w_ready", w_ready, 4'hF);
  endtask

  // Monitor: every r_valid pulse must match the next expected word for that thread
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (r_valid[i] === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected_t%0d: got pulse with data %0h, required no pulse", i, data_out[i*32 +: 32]);
        end else begin
          e_word = exp_q[i].pop_front();
          check($sformatf("rd_t%0d", i), data_out[i*32 +: 32], e_word);
        end
      end
    end
  end

  initial begin
    // Reset release, single write and read-back
    do_reset();
    step(8'h02, {96'h0, 32'hA0});
    check("a_w_ready", w_ready, 4'hF);
    step(8'h00, '0);
    check("a_commit_cnt", commit_cnt, 4'd1);
    expect_rd(0, 32'hA0);
    step(8'h01, '0);
    step(8'h00, '0);
    check("a_hold_data", data_out[31:0], 32'hA0);
    check("a_pulse_end", r_valid, 4'h0);

    // Four simultaneous writes drain t0..t3; reads reveal commit order
    do_reset();
    step(8'hAA, {32'h13, 32'h12, 32'h11, 32'h10});
    step(8'h00, '0);
    check("b_cnt1", commit_cnt, 4'd1);
    expect_rd(0, 32'h10); expect_rd(1, 32'h0);
    step(8'h05, '0);
    expect_rd(1, 32'h11); expect_rd(2, 32'h0);
    step(8'h14, '0);
    expect_rd(2, 32'h12); expect_rd(3, 32'h0);
    step(8'h50, '0);
    expect_rd(3, 32'h13);
    step(8'h40, '0);
    check("b_cnt4", commit_cnt, 4'd4);
    check("b_no_wrap", mem_wrapped, 1'b0);
    step(8'hAA, {32'h23, 32'h22, 32'h21, 32'h20});
    step(8'h00, '0);
    expect_rd(0, 32'h20); expect_rd(1, 32'h11);
    step(8'h05, '0);
    idle(2);
    check("b_cnt8", commit_cnt, 4'd8);
    check("b_wrap", mem_wrapped, 1'b1);
    expect_rd(2, 32'h22); expect_rd(3, 32'h23);
    step(8'h50, '0);

    // Thread 2 fills, drop on full, full-while-popped keeps w_ready low
    do_reset();
    step(8'hAA, {32'h31, 32'h21, 32'h11, 32'h01});
    step(8'hAA, {32'h32, 32'h22, 32'h12, 32'h02});
    step(8'h20, {32'h0, 32'h23, 64'h0});
    step(8'h20, {32'h0, 32'h24, 64'h0});
    step(8'h20, {32'h0, 32'h25, 64'h0});
    check("c_full", w_ready, 4'hB);
    check("c_no_drop_yet", drop_err, 4'h0);
    step(8'h20, {32'h0, 32'h26, 64'h0});
    check("c_drop", drop_err, 4'h4);
    check("c_still_full", w_ready, 4'hB);
    step(8'h00, '0);
    check("c_full_before_pop", w_ready, 4'hB);
    step(8'h00, '0);
    check("c_ready_again", w_ready, 4'hF);
    idle(6);
    expect_rd(0, 32'h02); expect_rd(1, 32'h12); expect_rd(2, 32'h25); expect_rd(3, 32'h32);
    step(8'h55, '0);
    check("c_drop_sticky", drop_err, 4'h4);
    check("c_cnt_sat", commit_cnt, 4'd8);

    // Read before any commit, and read racing the first commit
    do_reset();
    expect_rd(1, 32'h0);
    step(8'h04, '0);
    expect_rd(1, 32'h0);
    step(8'h0C, {64'h0, 32'h55, 32'h0});
    expect_rd(1, 32'h0);
    step(8'h04, '0);
    expect_rd(1, 32'h55);
    step(8'h04, '0);
    check("d_cnt", commit_cnt, 4'd1);

    // Nine commits into an eight-word memory
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step(8'h02, {96'h0, 32'(k)});
      if (k == 8) begin
        check("e_cnt7", commit_cnt, 4'd7);
        check("e_not_wrapped", mem_wrapped, 1'b0);
      end
    end
    check("e_cnt8", commit_cnt, 4'd8);
    check("e_wrapped", mem_wrapped, 1'b1);
    step(8'h00, '0);
    check("e_cnt_sat", commit_cnt, 4'd8);
    expect_rd(0, 32'd9);
    step(8'h01, '0);

    // Reset with three words queued discards them
    step(8'h2A, {32'h0, 32'h63, 32'h62, 32'h61});
    do_reset();
    idle(3);
    check("f_no_commit", commit_cnt, 4'd0);
    expect_rd(0, 32'h0); expect_rd(1, 32'h0); expect_rd(2, 32'h0);
    step(8'h15, '0);
    step(8'h80, {32'h77, 96'h0});
    step(8'h00, '0);
    check("f_cnt1", commit_cnt, 4'd1);
    expect_rd(3, 32'h77);
    step(8'h40, '0);

    idle(3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("q_drained_t%0d", i), exp_q[i].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arashi_rr_cache.md
Name: arashi_rr_cache

Overview:
- Multi-thread write-combining cache with per-thread FIFOs of configurable depth, a round-robin drain arbiter and an internal circular memory.
- Each thread can read back the last word it committed.
- Successor to the fixed four-thread cache/memory pair. Adds:
  - a per-thread write handshake with drop detection
  - fair arbitration
  - configurable thread count and FIFO depth
  - commit/wrap status outputs

Parameters:
- DATA_WIDTH, 32, width of one data word.
- THREAD_NUM_WIDTH, 2, log2 of thread count. THREAD_NUM = 1<<THREAD_NUM_WIDTH. Legal range 1..4; elaboration $error outside it.
- FIFO_DEPTH_WIDTH, 2, log2 of per-thread FIFO depth. FIFO_DEPTH = 1<<FIFO_DEPTH_WIDTH. Must be >=1; elaboration $error otherwise.
- MEM_WIDTH, 10, log2 of memory word count. MEM_DEPTH = 1<<MEM_WIDTH.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- ctrl  input  2*THREAD_NUM  per thread i: bit 2i+1 = write request, bit 2i = read request.
- data_in  input  DATA_WIDTH*THREAD_NUM  write data, thread i at slice [i*DATA_WIDTH +: DATA_WIDTH].
- w_ready  output  THREAD_NUM  1 = thread i FIFO can accept a word this cycle.
- drop_err  output  THREAD_NUM  sticky; set when a write is presented while w_ready[i]=0.
- data_out  output  DATA_WIDTH*THREAD_NUM  per-thread read-back data, registered.
- r_valid  output  THREAD_NUM  one-cycle pulse marking new data_out[i].
- commit_cnt  output  MEM_WIDTH+1  saturating count of words committed to memory.
- mem_wrapped  output  1  sticky; set when the memory write pointer first wraps.

Behaviour:
- Reset (rst=1 at posedge):
  - All FIFOs empty.
  - rr_ptr=0, wr_ptr=0.
  - last_addr and has_data cleared.
  - data_out, r_valid, drop_err, commit_cnt and mem_wrapped are 0.
  - w_ready is forced 0 while rst=1.
  - Memory contents are not cleared.
  - Reset mid-operation discards all queued words.
- Write handshake:
  - w_ready[i] = !rst && occupancy[i] < FIFO_DEPTH (combinational from registered occupancy).
  - Push when ctrl[2i+1] && w_ready[i].
  - If ctrl[2i+1] && !w_ready[i] outside reset: the word is dropped and drop_err[i] is set. drop_err clears only on reset.
- Arbitration and drain:
  - Decided each cycle on start-of-cycle occupancy.
  - Grant goes to the first non-empty thread scanning rr_ptr, rr_ptr+1, ... modulo THREAD_NUM.
  - On grant g: pop the head of FIFO g, write mem[wr_ptr] <= word, last_addr[g] <= wr_ptr, has_data[g] <= 1, wr_ptr <= wr_ptr+1, rr_ptr <= g+1 (mod THREAD_NUM).
  - No grant means no state change.
  - One commit per cycle maximum.
- Latency:
  - A word pushed at edge t is poppable at earliest cycle t+1 and is in memory after edge t+1.
  - A word pushed into an empty FIFO is never popped in its push cycle.
- Simultaneous events:
  - A push and a pop on the same FIFO in one cycle leaves occupancy unchanged.
  - A full FIFO being popped still shows w_ready=0 that cycle; no bypass.
- Wrap:
  - wr_ptr goes from MEM_DEPTH-1 to 0.
  - mem_wrapped is set on that edge and stays set.
  - Older words are overwritten silently.
- commit_cnt increments per commit and saturates at MEM_DEPTH.
- Read:
  - ctrl[2i] at edge t gives, at edge t+1: data_out[i] = has_data[i] ? mem[last_addr[i]] : 0, and r_valid[i]=1 for exactly one cycle.
  - The read uses start-of-cycle state. A same-cycle commit by thread i returns the previous committed word; a same-cycle overwrite of last_addr[i] by another thread returns the old contents.
  - Without a read request, data_out[i] holds its value and r_valid[i]=0.
- Read and write bits set together are both honoured independently.

Test Plan:
- Reset release, THREAD_NUM=4, FIFO_DEPTH=4:
  - Write 0xA0 on thread 0 -> w_ready=4'hF after reset.
  - Memory holds 0xA0 at address 0 after 2 edges.
  - commit_cnt=1.
  - Read on thread 0 -> data_out[0]=0xA0 with a single r_valid pulse.
- All four threads write in the same cycle (0x10, 0x11, 0x12, 0x13) -> commits in order t0, t1, t2, t3 at addresses 0..3, one per cycle.
  - Next simultaneous burst starts at thread 0 again (rr_ptr=0 after t3).
- Thread 2 writes 5 words back-to-back while the other threads keep FIFOs busy -> w_ready[2] drops when occupancy hits 4.
  - A 6th write presented while full sets drop_err[2]=1, and that word never appears in memory.
- Read with no prior commit on thread 1 -> data_out[1]=0, r_valid[1]=1.
  - Read issued in the same cycle as thread 1's first commit (0x55) -> returns 0; the next read returns 0x55.
- MEM_WIDTH=3, commit 9 words (values 1..9) -> mem_wrapped=1 after the 8th commit.
  - Word 9 is at address 0.
  - commit_cnt saturates at 8.
- Assert rst with 3 words queued -> all FIFOs empty and w_ready=0 during reset.
  - No further commits occur.
  - After release, a new write lands at address 0.
